// File: rtl/uop_logic_pkg.sv
// Shared constants, types and helpers for the two-input logic teaching cells.
`timescale 1ns/1ps
package uop_logic_pkg;

  // A two-input gate has four minterms, indexed as {a, b}.
  localparam int unsigned NUM_MINTERMS_2IN = 4;

  typedef logic [1:0] minterm2_t;

  // Per-bit equivalence. Plain operators keep 4-state X/Z propagation.
  function automatic logic xnor_bit(input logic a, input logic b);
    return ~(a ^ b);
  endfunction

endpackage

// File: rtl/uop_minterm_cov.sv
// Sticky coverage register for the four minterms of a two-input lane.
// all_seen_o rises on the same edge that records the last missing minterm.
`timescale 1ns/1ps
module uop_minterm_cov
  import uop_logic_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        en_i,
  input  minterm2_t                   minterm_i,
  output logic [NUM_MINTERMS_2IN-1:0] seen_o,
  output logic                        all_seen_o
);

  logic [NUM_MINTERMS_2IN-1:0] seen_q, seen_d, hit;
  logic                        all_seen_q, all_seen_d;

  // Next-state: OR in the one-hot of the sampled minterm; hold when disabled.
  always_comb begin
    hit             = '0;
    hit[minterm_i]  = 1'b1;
    seen_d          = seen_q;
    all_seen_d      = all_seen_q;
    if (en_i) begin
      seen_d     = seen_q | hit;
      // Judge completion on the updated mask, not the old one.
      all_seen_d = &(seen_q | hit);
    end
  end

  // State register with synchronous reset taking priority over enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seen_q     <= '0;
      all_seen_q <= 1'b0;
    end else begin
      seen_q     <= seen_d;
      all_seen_q <= all_seen_d;
    end
  end

  assign seen_o     = seen_q;
  assign all_seen_o = all_seen_q;

endmodule

// File: rtl/uop_nxor_gate.sv
// Parameterised bitwise XNOR with a registered copy and lane-0 minterm coverage.
`timescale 1ns/1ps
module uop_nxor_gate
  import uop_logic_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [WIDTH-1:0]            y,
  input  logic [WIDTH-1:0]            a,
  input  logic [WIDTH-1:0]            b,
  input  logic                        en,
  output logic [WIDTH-1:0]            y_q,
  output logic                        all_eq,
  output logic [NUM_MINTERMS_2IN-1:0] seen,
  output logic                        all_seen
);

  logic [WIDTH-1:0] y_reg_q, y_reg_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    assign y[i] = xnor_bit(a[i], b[i]);
  end

  assign all_eq = &y;

  // Next-state for the registered copy: capture y when enabled, else hold.
  always_comb begin
    y_reg_d = y_reg_q;
    if (en) begin
      y_reg_d = y;
    end
  end

  // Registered copy with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg_q <= '0;
    end else begin
      y_reg_q <= y_reg_d;
    end
  end

  assign y_q = y_reg_q;

  uop_minterm_cov u_cov (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .minterm_i  ({a[0], b[0]}),
    .seen_o     (seen),
    .all_seen_o (all_seen)
  );

endmodule

// File: tb/tb_uop_nxor_gate.sv
// Self-checking bench for uop_nxor_gate: WIDTH=1 and WIDTH=8 instances.
`timescale 1ns/1ps
module tb_uop_nxor_gate;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8, en8;
  logic [7:0] a8, b8, y8, yq8;
  logic       all_eq8, all_seen8;
  logic [3:0] seen8;

  // WIDTH=1 instance
  logic       rst1, en1;
  logic [0:0] a1, b1, y1, yq1;
  logic       all_eq1, all_seen1;
  logic [3:0] seen1;

  uop_nxor_gate #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .y(y8), .a(a8), .b(b8), .en(en8),
    .y_q(yq8), .all_eq(all_eq8), .seen(seen8), .all_seen(all_seen8)
  );

  uop_nxor_gate #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst1), .y(y1), .a(a1), .b(b1), .en(en1),
    .y_q(yq1), .all_eq(all_eq1), .seen(seen1), .all_seen(all_seen1)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit       r;
    bit       e;
    bit [7:0] a;
    bit [7:0] b;
    bit [7:0] ey;
    bit [7:0] eyq;
    bit [3:0] eseen;
    bit       eall;
  } vec_t;

  vec_t tbl[10];

  // Reference model state (set-of-minterms view).
  bit       m_seen[4];
  bit [7:0] m_yq;

  function automatic bit [7:0] ref_y(input bit [7:0] av, input bit [7:0] bv);
    bit [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (av[i] == bv[i]);
    return r;
  endfunction

  function automatic bit [3:0] ref_seen_mask();
    bit [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = m_seen[k];
    return m;
  endfunction

  initial begin
    bit [3:0] tt;
    rst8 = 1'b0; en8 = 1'b0; a8 = '0; b8 = '0;
    rst1 = 1'b0; en1 = 1'b0; a1 = '0; b1 = '0;

    // Exhaustive truth table on WIDTH=1, purely combinational.
    tt = 4'b1001;
    for (int v = 0; v < 4; v++) begin
      {a1, b1} = 2'(v);
      #0.05;
      chk($sformatf("tt_y[%0d]", v), 32'(y1), 32'(tt[v]));
      chk($sformatf("tt_all_eq[%0d]", v), 32'(all_eq1), 32'(tt[v]));
    end

    // Align to just after a rising edge.
    @(posedge clk); #1;

    // Coverage ordering, enable hold on 8 lanes, reset mid-sequence.
    tbl[0] = '{1, 1, 8'hA5, 8'hA5, 8'hFF, 8'h00, 4'b0000, 0};
    tbl[1] = '{0, 1, 8'h01, 8'h01, 8'hFF, 8'hFF, 4'b1000, 0};
    tbl[2] = '{0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 4'b1001, 0};
    tbl[3] = '{0, 1, 8'h01, 8'h01, 8'hFF, 8'hFF, 4'b1001, 0};
    tbl[4] = '{0, 1, 8'h00, 8'h01, 8'hFE, 8'hFE, 4'b1011, 0};
    tbl[5] = '{0, 1, 8'h01, 8'h00, 8'hFE, 8'hFE, 4'b1111, 1};
    tbl[6] = '{0, 0, 8'hA5, 8'h5A, 8'h00, 8'hFE, 4'b1111, 1};
    tbl[7] = '{1, 1, 8'hF0, 8'hFF, 8'hF0, 8'h00, 4'b0000, 0};
    tbl[8] = '{0, 1, 8'h00, 8'h00, 8'hFF, 8'hFF, 4'b0001, 0};
    tbl[9] = '{0, 1, 8'h00, 8'h01, 8'hFE, 8'hFE, 4'b0011, 0};

    for (int i = 0; i < 10; i++) begin
      rst8 = tbl[i].r; en8 = tbl[i].e; a8 = tbl[i].a; b8 = tbl[i].b;
      #1;
      chk($sformatf("tbl[%0d].y", i), 32'(y8), 32'(tbl[i].ey));
      chk($sformatf("tbl[%0d].all_eq", i), 32'(all_eq8), 32'(tbl[i].ey == 8'hFF));
      @(posedge clk); #1;
      chk($sformatf("tbl[%0d].y_q", i), 32'(yq8), 32'(tbl[i].eyq));
      chk($sformatf("tbl[%0d].seen", i), 32'(seen8), 32'(tbl[i].eseen));
      chk($sformatf("tbl[%0d].all_seen", i), 32'(all_seen8), 32'(tbl[i].eall));
    end

    // Enable hold on WIDTH=1: build seen=0011 with y_q=1, then freeze.
    rst1 = 1'b1; en1 = 1'b1; {a1, b1} = 2'b11;
    @(posedge clk); #1;
    rst1 = 1'b0; {a1, b1} = 2'b01;
    @(posedge clk); #1;
    {a1, b1} = 2'b00;
    @(posedge clk); #1;
    chk("hold_pre_seen", 32'(seen1), 32'(4'b0011));
    chk("hold_pre_y_q", 32'(yq1), 32'(1));
    en1 = 1'b0; {a1, b1} = 2'b01;
    #1;
    chk("hold_y_now", 32'(y1), 32'(0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_seen[%0d]", c), 32'(seen1), 32'(4'b0011));
      chk($sformatf("hold_y_q[%0d]", c), 32'(yq1), 32'(1));
      chk($sformatf("hold_all_seen[%0d]", c), 32'(all_seen1), 32'(0));
    end

    // Randomised run on WIDTH=8 against the reference model.
    for (int k = 0; k < 4; k++) m_seen[k] = 0;
    m_yq = '0;
    rst8 = 1'b1; en8 = 1'b0; a8 = '0; b8 = '0;
    @(posedge clk); #1;
    for (int n = 0; n < 300; n++) begin
      bit       r, e;
      bit [7:0] av, bv, ey;
      bit [3:0] ms;
      r  = ($urandom_range(0, 29) == 0);
      e  = ($urandom_range(0, 3) != 0);
      av = 8'($urandom);
      bv = ($urandom_range(0, 5) == 0) ? av : 8'($urandom);
      rst8 = r; en8 = e; a8 = av; b8 = bv;
      ey = ref_y(av, bv);
      #1;
      chk($sformatf("rnd[%0d].y", n), 32'(y8), 32'(ey));
      chk($sformatf("rnd[%0d].all_eq", n), 32'(all_eq8), 32'(av == bv));
      @(posedge clk); #1;
      if (r) begin
        for (int k = 0; k < 4; k++) m_seen[k] = 0;
        m_yq = '0;
      end else if (e) begin
        m_seen[2 * int'(av[0]) + int'(bv[0])] = 1;
        m_yq = ey;
      end
      ms = ref_seen_mask();
      chk($sformatf("rnd[%0d].y_q", n), 32'(yq8), 32'(m_yq));
      chk($sformatf("rnd[%0d].seen", n), 32'(seen8), 32'(ms));
      chk($sformatf("rnd[%0d].all_seen", n), 32'(all_seen8), 32'(ms == 4'hF));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uop_nxor_gate.md
Name: uop_nxor_gate

Overview:
- Parameterised bitwise XNOR (equivalence) block: combinational result y = ~(a ^ b) per bit, plus a registered copy.
- Adds a small minterm-coverage tracker on lane 0 so a bench can confirm all four input combinations {a[0],b[0]} = 00, 01, 10, 11 have been applied.
- Leaf cell in the digital-systems teaching library.
- Combinational path has zero latency; registered and status outputs update on clk.

Parameters:
- WIDTH, 1, number of independent XNOR lanes (≥1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous, active-high reset.
- y  output  WIDTH  combinational XNOR: y[i] = ~(a[i] ^ b[i]).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- en  input  1  sample enable for y_q and the coverage tracker.
- y_q  output  WIDTH  registered y.
- all_eq  output  1  combinational; 1 when a == b on every lane (&y).
- seen  output  4  registered coverage mask; bit m set once minterm m = {a[0],b[0]} is sampled.
- all_seen  output  1  registered; 1 when seen == 4'b1111.
- Interface: one clock; reset is synchronous and active-high.

Behaviour:
- Combinational outputs:
  - y and all_eq depend only on a and b, with no clock or reset dependence.
  - Required truth table per lane: 00→1, 01→0, 10→0, 11→1.
  - y is valid within the same delta or timestep as the input change.
- Reset (rst=1 at a rising clk edge):
  - y_q ← 0, seen ← 0, all_seen ← 0.
  - rst has priority over en.
  - Reset mid-sequence discards prior coverage.
- Normal operation (rst=0, en=1, rising edge):
  - y_q ← y.
  - seen[{a[0],b[0]}] ← 1.
  - all_seen ← (seen | onehot({a[0],b[0]})) == 4'b1111, so all_seen rises on the same edge the final minterm is recorded.
- en=0: y_q, seen and all_seen hold.
- seen bits are sticky; only rst clears them. Repeating a minterm has no effect.
- Only lane 0 feeds coverage. Lanes 1..WIDTH-1 affect y, y_q and all_eq only.
- X or Z on a or b propagates per standard 4-state operators; no masking.
- No internal state other than y_q, seen and all_seen.
- Latency: y and all_eq 0 cycles; y_q, seen and all_seen 1 cycle.

Decomposition:
- Shared package uop_logic_pkg holds:
  - constant NUM_MINTERMS_2IN = 4;
  - typedef minterm2_t (logic [1:0]);
  - function xnor_bit(a,b).
- One natural sub-module: uop_minterm_cov, the 4-bit sticky coverage register plus all_seen generation, instantiated once on lane 0.
- The XNOR array is a generate loop in the top module.

Test Plan:
- Exhaustive truth table, WIDTH=1, no clock needed: drive {a,b} = 0,1,2,3 with 50 ps spacing → y = 1,0,0,1 and all_eq = 1,0,0,1.
- Reset: rst=1 for one edge after random activity → y_q=0, seen=4'b0000, all_seen=0; with rst=1 and en=1 together, reset wins.
- Coverage ordering, en=1, one minterm per clk:
  - Apply 3, 0, 3, 1 → seen = 1000, 1001, 1001, 1011 and all_seen = 0.
  - Then apply 2 → seen = 1111 and all_seen = 1 on that same edge.
- Enable hold: after seen=4'b0011 and y_q=1, drive en=0 with {a,b}=2'b01 for 3 cycles → seen=0011 and y_q=1 unchanged, while y=0 immediately.
- Multi-lane, WIDTH=8:
  - a=8'hA5, b=8'hA5 → y=8'hFF, all_eq=1.
  - a=8'hA5, b=8'h5A → y=8'h00, all_eq=0.
  - a=8'hF0, b=8'hFF → y=8'hF0.
  - y_q matches y one cycle later.
- Sticky and reset-mid-operation: reach all_seen=1, pulse rst, apply 0 then 1 → seen=0001, then seen=0011, with all_seen=0 throughout.
